// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, ALU flag-select encodings
// and the flag/branch unit FSM states.
package cpu_pkg;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam logic [1:0] FSEL_NONE = 2'b00;
  localparam logic [1:0] FSEL_Z    = 2'b01;
  localparam logic [1:0] FSEL_ALL  = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition code against the V/Z/N flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      CC_NEQ:    cond_true = ~z;
      CC_EQ:     cond_true = z;
      CC_GT:     cond_true = ~z & ~n;
      CC_LT:     cond_true = n;
      CC_GTE:    cond_true = z | ~n;
      CC_LTE:    cond_true = n | z;
      CC_OVFL:   cond_true = v;
      CC_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage flag register (V/Z/N) with addz suppression, plus branch resolution
// driving a one-cycle PC redirect and a FLUSH_CYCLES-long wrong-path flush.
module flag_branch_unit
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [1:0]      ex_flag_sel,
  input  logic            ex_is_addz,
  input  logic            alu_ov,
  input  logic            alu_zr,
  input  logic            alu_ne,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic            flag_z,
  output logic            flag_v,
  output logic            flag_n,
  output logic            ex_addz_kill,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_o
);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            z_q, z_d;
  logic            v_q, v_d;
  logic            n_q, n_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;

  logic act;
  logic cond_true;
  logic taken;

  assign act          = ex_valid & ~stall & (state_q == ST_RUN);
  assign ex_addz_kill = ex_valid & ex_is_addz & ~z_q;
  assign taken        = act & br_valid & cond_true;

  branch_cond_eval u_cond (
    .br_cond   (br_cond),
    .z         (z_q),
    .v         (v_q),
    .n         (n_q),
    .cond_true (cond_true)
  );

  always_comb begin
    z_d = z_q;
    v_d = v_q;
    n_d = n_q;
    if (act && !ex_addz_kill) begin
      case (ex_flag_sel)
        FSEL_ALL: begin
          z_d = alu_zr;
          v_d = alu_ov;
          n_d = alu_ne;
        end
        FSEL_Z:    z_d = alu_zr;
        FSEL_NONE: ;
        default:   ;
      endcase
    end
  end

  // cnt counts the flush cycles remaining after the current one, independent of stall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    case (state_q)
      ST_RUN: begin
        flush_d = 1'b0;
        if (taken) begin
          redirect_d    = 1'b1;
          redirect_pc_d = br_target;
          flush_d       = 1'b1;
          cnt_d         = 3'(FLUSH_CYCLES - 1);
          state_d       = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          flush_d = 1'b1;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      z_q           <= 1'b0;
      v_q           <= 1'b0;
      n_q           <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      z_q           <= z_d;
      v_q           <= v_d;
      n_q           <= n_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  assign flag_z      = z_q;
  assign flag_v      = v_q;
  assign flag_n      = n_q;
  assign redirect_o  = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush_o     = flush_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: default FLUSH_CYCLES=2 instance plus a
// FLUSH_CYCLES=1 instance used for back-to-back branch resolution.
module tb_flag_branch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic [1:0]  ex_flag_sel;
  logic        ex_is_addz;
  logic        alu_ov;
  logic        alu_zr;
  logic        alu_ne;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic        flag_z, flag_v, flag_n, ex_addz_kill, redirect_o, flush_o;
  logic [15:0] redirect_pc;

  logic        ex_valid1, br_valid1;
  logic        flag_z1, flag_v1, flag_n1, ex_addz_kill1, redirect_o1, flush_o1;
  logic [15:0] redirect_pc1;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  flag_branch_unit #(.FLUSH_CYCLES(2), .PC_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_flag_sel  (ex_flag_sel),
    .ex_is_addz   (ex_is_addz),
    .alu_ov       (alu_ov),
    .alu_zr       (alu_zr),
    .alu_ne       (alu_ne),
    .br_valid     (br_valid),
    .br_cond      (br_cond),
    .br_target    (br_target),
    .flag_z       (flag_z),
    .flag_v       (flag_v),
    .flag_n       (flag_n),
    .ex_addz_kill (ex_addz_kill),
    .redirect_o   (redirect_o),
    .redirect_pc  (redirect_pc),
    .flush_o      (flush_o)
  );

  flag_branch_unit #(.FLUSH_CYCLES(1), .PC_W(16)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .ex_valid     (ex_valid1),
    .ex_flag_sel  (ex_flag_sel),
    .ex_is_addz   (ex_is_addz),
    .alu_ov       (alu_ov),
    .alu_zr       (alu_zr),
    .alu_ne       (alu_ne),
    .br_valid     (br_valid1),
    .br_cond      (br_cond),
    .br_target    (br_target),
    .flag_z       (flag_z1),
    .flag_v       (flag_v1),
    .flag_n       (flag_n1),
    .ex_addz_kill (ex_addz_kill1),
    .redirect_o   (redirect_o1),
    .redirect_pc  (redirect_pc1),
    .flush_o      (flush_o1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic addz,
                               input logic ov, input logic zr, input logic ne,
                               input logic bv, input logic [2:0] cc,
                               input logic [15:0] tgt, input logic stl);
    ex_valid    = v;
    ex_flag_sel = sel;
    ex_is_addz  = addz;
    alu_ov      = ov;
    alu_zr      = zr;
    alu_ne      = ne;
    br_valid    = bv;
    br_cond     = cc;
    br_target   = tgt;
    stall       = stl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic v, input logic n);
    checkOutput({tag, "_z"}, {31'd0, flag_z}, {31'd0, z});
    checkOutput({tag, "_v"}, {31'd0, flag_v}, {31'd0, v});
    checkOutput({tag, "_n"}, {31'd0, flag_n}, {31'd0, n});
  endtask

  task automatic checkBranch(input string tag, input logic r, input logic [15:0] pc,
                             input logic f);
    checkOutput({tag, "_redirect"}, {31'd0, redirect_o}, {31'd0, r});
    checkOutput({tag, "_pc"}, {16'd0, redirect_pc}, {16'd0, pc});
    checkOutput({tag, "_flush"}, {31'd0, flush_o}, {31'd0, f});
  endtask

  initial begin
    rst_n     = 1'b0;
    ex_valid1 = 1'b0;
    br_valid1 = 1'b0;
    idle();
    #12;
    checkFlags("rst", 1'b0, 1'b0, 1'b0);
    checkBranch("rst", 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;

    // T2: sub 5-5, add setting all flags, then and clearing only Z
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("sub_eq", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("add_all", 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("and_zonly", 1'b0, 1'b1, 1'b1);

    // T3: addz with Z=0 is killed, with Z=1 it updates
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    #1;
    checkOutput("addz_kill_z0", {31'd0, ex_addz_kill}, 32'd1);
    tick();
    checkFlags("addz_killed", 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("sub_setz", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 16'h0, 1'b0);
    #1;
    checkOutput("addz_kill_z1", {31'd0, ex_addz_kill}, 32'd0);
    tick();
    checkFlags("addz_live", 1'b0, 1'b1, 1'b1);

    // T4: clear flags, gt taken, wrong-path branch ignored during flush
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("sub_clr", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 16'h0040, 1'b0);
    tick();
    checkBranch("gt_taken", 1'b1, 16'h0040, 1'b1);
    checkFlags("gt_noflag", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 16'h0099, 1'b0);
    tick();
    checkBranch("flush_c2", 1'b0, 16'h0040, 1'b1);
    checkFlags("flush_noflag", 1'b0, 1'b0, 1'b0);
    tick();
    checkBranch("flush_end", 1'b0, 16'h0040, 1'b0);
    checkFlags("flush_noflag2", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 16'h0077, 1'b0);
    tick();
    checkBranch("lt_nottaken", 1'b0, 16'h0040, 1'b0);

    // T5: stalled taken branch resolves only once stall drops
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 16'h0, 1'b1);
    tick();
    checkFlags("stall_noflag", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 16'h0123, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold_redirect", {31'd0, redirect_o}, 32'd0);
    end
    stall = 1'b0;
    tick();
    checkBranch("stall_release", 1'b1, 16'h0123, 1'b1);
    idle();
    tick();
    checkBranch("stall_flush2", 1'b0, 16'h0123, 1'b1);
    tick();
    checkBranch("stall_flush_end", 1'b0, 16'h0123, 1'b0);

    // T6: overflow sets V, ovfl branch taken
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("ovf_add", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 16'h0200, 1'b0);
    tick();
    checkBranch("ovfl_taken", 1'b1, 16'h0200, 1'b1);
    idle();
    tick();
    tick();
    checkBranch("ovfl_done", 1'b0, 16'h0200, 1'b0);

    // Reset asserted in the middle of a flush
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 16'h0300, 1'b0);
    tick();
    checkBranch("pre_reset", 1'b1, 16'h0300, 1'b1);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    checkBranch("async_reset", 1'b0, 16'h0000, 1'b0);
    checkFlags("async_reset", 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    checkBranch("post_reset", 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 16'h0, 1'b0);
    tick();
    checkFlags("post_reset_sub", 1'b1, 1'b0, 1'b1);

    // FLUSH_CYCLES=1 instance: unconditional branches held in EX back to back
    idle();
    ex_flag_sel = 2'b00;
    br_cond     = 3'b111;
    br_target   = 16'h0055;
    ex_valid1   = 1'b1;
    br_valid1   = 1'b1;
    tick();
    checkOutput("fc1_redirect_a", {31'd0, redirect_o1}, 32'd1);
    checkOutput("fc1_flush_a", {31'd0, flush_o1}, 32'd1);
    checkOutput("fc1_pc_a", {16'd0, redirect_pc1}, 32'h0055);
    tick();
    checkOutput("fc1_redirect_gap", {31'd0, redirect_o1}, 32'd0);
    checkOutput("fc1_flush_gap", {31'd0, flush_o1}, 32'd0);
    br_target = 16'h0066;
    tick();
    checkOutput("fc1_redirect_b", {31'd0, redirect_o1}, 32'd1);
    checkOutput("fc1_pc_b", {16'd0, redirect_pc1}, 32'h0066);
    checkOutput("fc1_main_idle", {31'd0, redirect_o}, 32'd0);
    ex_valid1 = 1'b0;
    br_valid1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
